// File: rtl/issue_unit_n_pkg.sv
// issue_unit_n_pkg: shared types and constants for the multi-issue stage
package issue_unit_n_pkg;
  localparam int REG_ADDR = 5;
  localparam int REG_WIDTH = 32;
  localparam int IQ_ADDR = 4;
  localparam int DEFAULT_STAGES = 3;
  localparam int MAX_STAGES = 7;
  localparam int STAGE_W = 3;
  typedef enum logic [2:0] {EXE_ALU, EXE_MUL, EXE_LOAD, EXE_STORE, EXE_BRANCH} exe_type_e;
  typedef struct packed {
    logic num1_need;
    logic [REG_ADDR-1:0] num1_addr;
    logic [REG_WIDTH-1:0] num1;
    logic num2_need;
    logic [REG_ADDR-1:0] num2_addr;
    logic [REG_WIDTH-1:0] num2;
    logic dst_need;
    logic [REG_ADDR-1:0] dst_addr;
    exe_type_e exe_type;
    logic [STAGE_W-1:0] avail_stage;
  } ISSUE_QUEUE_ELEMENT;
  typedef struct packed {
    logic valid;
    logic [REG_WIDTH-1:0] num1;
    logic [REG_WIDTH-1:0] num2;
    logic dst_need;
    logic [REG_ADDR-1:0] dst_addr;
    exe_type_e exe_type;
  } FU_REQUIRE;
  // Bit k of either field stands for producer stage k+1; bits at or above STAGES stay 0.
  typedef struct packed {
    logic [MAX_STAGES-1:0] position;
    logic [MAX_STAGES-1:0] accept_mask;
  } SCORE_BOARD_DATA;
  function automatic logic [MAX_STAGES-1:0] accept_from(input logic [STAGE_W-1:0] avail);
    for (int k = 0; k < MAX_STAGES; k++) accept_from[k] = (k + 1) >= int'(avail);
  endfunction
endpackage

// File: rtl/issue_unit_n_score_board.sv
// score_board_n: per-register producer position and result-availability tracker
module score_board_n
  import issue_unit_n_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int NREG = 32,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  input  logic flush,
  input  logic [2*ISSUE_W-1:0][REG_ADDR-1:0] rd_addr,
  output SCORE_BOARD_DATA [2*ISSUE_W-1:0] rd_data,
  input  logic [ISSUE_W-1:0] wr_en,
  input  logic [ISSUE_W-1:0][REG_ADDR-1:0] wr_addr,
  input  logic [ISSUE_W-1:0][STAGE_W-1:0] wr_avail
);
  localparam logic [MAX_STAGES-1:0] STAGE_MASK = MAX_STAGES'((1 << STAGES) - 1);
  SCORE_BOARD_DATA sb [NREG];
  always_comb
    for (int o = 0; o < 2*ISSUE_W; o++) rd_data[o] = sb[rd_addr[o]];
  // Later write ports are younger slots, so their assignment lands last and wins.
  always_ff @(posedge clk or posedge rst)
    if (rst || flush) begin
      for (int r = 0; r < NREG; r++) sb[r] <= '0;
    end else if (!stall) begin
      for (int r = 0; r < NREG; r++) sb[r].position <= (sb[r].position << 1) & STAGE_MASK;
      for (int i = 0; i < ISSUE_W; i++)
        if (wr_en[i])
          sb[wr_addr[i]] <= '{position: MAX_STAGES'(1), accept_mask: accept_from(wr_avail[i]) & STAGE_MASK};
    end
endmodule

// File: rtl/issue_unit_n.sv
// issue_unit_n: in-order multi-issue select with scoreboard, operand bypass and registered FU request
module issue_unit_n
  import issue_unit_n_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int NREG = 32,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  ISSUE_QUEUE_ELEMENT [ISSUE_W-1:0] iq_head,
  input  logic [IQ_ADDR-1:0] iq_size,
  output logic [$clog2(ISSUE_W+1)-1:0] iq_pop_number,
  input  logic stall,
  input  logic flush,
  output logic [2*ISSUE_W-1:0][REG_ADDR-1:0] regfile_read_addr,
  input  logic [2*ISSUE_W-1:0][REG_WIDTH-1:0] regfile_read_data,
  input  logic [STAGES-1:0][REG_WIDTH-1:0] bypass_data,
  output FU_REQUIRE [ISSUE_W-1:0] fu_require
);
  localparam int CW = $clog2(ISSUE_W + 1);
  SCORE_BOARD_DATA [2*ISSUE_W-1:0] sb_rd;
  logic [2*ISSUE_W-1:0] op_need, op_rdy;
  logic [2*ISSUE_W-1:0][REG_WIDTH-1:0] op_imm, op_byp, op_val;
  logic [ISSUE_W-1:0] raw, elig, issue, wr_en;
  logic [ISSUE_W-1:0][REG_ADDR-1:0] wr_addr;
  logic [ISSUE_W-1:0][STAGE_W-1:0] wr_avail;
  logic [CW-1:0] n;
  logic run, kill;
  assign kill = stall | flush;
  assign iq_pop_number = kill ? '0 : n;
  always_comb
    for (int i = 0; i < ISSUE_W; i++) begin
      regfile_read_addr[2*i] = iq_head[i].num1_addr;
      regfile_read_addr[2*i+1] = iq_head[i].num2_addr;
      op_need[2*i] = iq_head[i].num1_need;
      op_need[2*i+1] = iq_head[i].num2_need;
      op_imm[2*i] = iq_head[i].num1;
      op_imm[2*i+1] = iq_head[i].num2;
    end
  always_comb
    for (int o = 0; o < 2*ISSUE_W; o++) begin
      op_byp[o] = '0;
      for (int k = 0; k < STAGES; k++) if (sb_rd[o].position[k]) op_byp[o] |= bypass_data[k];
      op_rdy[o] = !op_need[o] || regfile_read_addr[o] == '0 || sb_rd[o].position == '0 ||
                  (sb_rd[o].position & sb_rd[o].accept_mask) != '0;
      op_val[o] = !op_need[o] ? op_imm[o] :
                  regfile_read_addr[o] == '0 ? '0 :
                  sb_rd[o].position == '0 ? regfile_read_data[o] : op_byp[o];
    end
  // Only the in-order prefix issues, so a RAW check against every older slot suffices.
  always_comb begin
    n = '0;
    run = 1'b1;
    for (int i = 0; i < ISSUE_W; i++) begin
      raw[i] = 1'b0;
      for (int j = 0; j < i; j++)
        raw[i] |= iq_head[j].dst_need && iq_head[j].dst_addr != '0 &&
                  ((iq_head[i].num1_need && iq_head[i].num1_addr == iq_head[j].dst_addr) ||
                   (iq_head[i].num2_need && iq_head[i].num2_addr == iq_head[j].dst_addr));
      elig[i] = IQ_ADDR'(i) < iq_size && op_rdy[2*i] && op_rdy[2*i+1] && !raw[i] &&
                (iq_head[i].exe_type != EXE_BRANCH || i == 0);
      run = run && elig[i];
      n = run ? n + CW'(1) : n;
      issue[i] = run && !kill;
      wr_en[i] = issue[i] && iq_head[i].dst_need && iq_head[i].dst_addr != '0;
      wr_addr[i] = iq_head[i].dst_addr;
      wr_avail[i] = iq_head[i].avail_stage;
    end
  end
  score_board_n #(.ISSUE_W(ISSUE_W), .NREG(NREG), .STAGES(STAGES)) u_score_board (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .flush(flush),
    .rd_addr(regfile_read_addr),
    .rd_data(sb_rd),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_avail(wr_avail)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst || flush) fu_require <= '0;
    else if (!stall)
      for (int i = 0; i < ISSUE_W; i++)
        if (issue[i])
          fu_require[i] <= '{valid: 1'b1, num1: op_val[2*i], num2: op_val[2*i+1],
                             dst_need: iq_head[i].dst_need, dst_addr: iq_head[i].dst_addr,
                             exe_type: iq_head[i].exe_type};
        else fu_require[i] <= '0;
endmodule

// File: tb/tb_issue_unit_n.sv
// tb_issue_unit_n: directed vectors for issue_unit_n with hand-computed expectations
module tb_issue_unit_n;
  import issue_unit_n_pkg::*;
  logic clk = 1'b0;
  logic rst, stall, flush;
  ISSUE_QUEUE_ELEMENT [1:0] iq_head;
  logic [IQ_ADDR-1:0] iq_size;
  logic [1:0] iq_pop_number;
  logic [3:0][REG_ADDR-1:0] regfile_read_addr;
  logic [3:0][REG_WIDTH-1:0] regfile_read_data;
  logic [2:0][REG_WIDTH-1:0] bypass_data;
  FU_REQUIRE [1:0] fu_require;
  int tests = 0;
  int fails = 0;
  issue_unit_n #(.ISSUE_W(2), .NREG(32), .STAGES(3)) dut (
    .clk(clk),
    .rst(rst),
    .iq_head(iq_head),
    .iq_size(iq_size),
    .iq_pop_number(iq_pop_number),
    .stall(stall),
    .flush(flush),
    .regfile_read_addr(regfile_read_addr),
    .regfile_read_data(regfile_read_data),
    .bypass_data(bypass_data),
    .fu_require(fu_require)
  );
  always #5 clk = ~clk;
  // Register file model: register r reads as 0x1000 + r.
  always_comb
    for (int o = 0; o < 4; o++) regfile_read_data[o] = 32'h1000 + 32'(regfile_read_addr[o]);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  function automatic ISSUE_QUEUE_ELEMENT mk(input logic [4:0] d, input logic [4:0] a1, input logic [4:0] a2,
                                            input exe_type_e t, input logic [2:0] av);
    mk = '0;
    mk.num1_need = 1'b1;
    mk.num1_addr = a1;
    mk.num2_need = 1'b1;
    mk.num2_addr = a2;
    mk.dst_need = d != 5'd0;
    mk.dst_addr = d;
    mk.exe_type = t;
    mk.avail_stage = av;
  endfunction
  task automatic step(input string tag, input logic [1:0] exp_pop);
    #1 check({tag, " pop"}, 32'(iq_pop_number), 32'(exp_pop));
    @(posedge clk);
    #1;
  endtask
  initial begin
    ISSUE_QUEUE_ELEMENT imm_op;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; iq_size = '0; iq_head = '0;
    for (int k = 0; k < 3; k++) bypass_data[k] = 32'hB000_0000 + 32'(k);
    #3;
    check("reset valid0", 32'(fu_require[0].valid), 32'd0);
    check("reset valid1", 32'(fu_require[1].valid), 32'd0);
    check("reset num1", fu_require[0].num1, 32'd0);
    check("reset pop", 32'(iq_pop_number), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    // independent pair
    iq_head[0] = mk(1, 2, 3, EXE_ALU, 1); iq_head[1] = mk(4, 5, 6, EXE_ALU, 1); iq_size = 2;
    #1 check("pair rf addr1", 32'(regfile_read_addr[1]), 32'd3);
    step("pair", 2);
    check("pair v0", 32'(fu_require[0].valid), 32'd1);
    check("pair v1", 32'(fu_require[1].valid), 32'd1);
    check("pair s0 num1", fu_require[0].num1, 32'h1002);
    check("pair s0 num2", fu_require[0].num2, 32'h1003);
    check("pair s1 num1", fu_require[1].num1, 32'h1005);
    check("pair s1 dst", 32'(fu_require[1].dst_addr), 32'd4);
    // intra-group RAW on r7
    iq_head[0] = mk(7, 10, 11, EXE_ALU, 1); iq_head[1] = mk(9, 7, 12, EXE_ALU, 1);
    step("raw", 1);
    check("raw s0 num1", fu_require[0].num1, 32'h100A);
    check("raw v1", 32'(fu_require[1].valid), 32'd0);
    // back-to-back bypass plus an immediate operand in slot 1
    imm_op = mk(15, 0, 0, EXE_ALU, 1); imm_op.num1_need = 1'b0; imm_op.num1 = 32'hDEAD;
    iq_head[0] = mk(9, 7, 12, EXE_ALU, 1); iq_head[1] = imm_op;
    step("b2b", 2);
    check("b2b s0 num1", fu_require[0].num1, 32'hB000_0000);
    check("b2b s0 num2", fu_require[0].num2, 32'h100C);
    check("b2b s1 imm", fu_require[1].num1, 32'hDEAD);
    check("b2b s1 zero", fu_require[1].num2, 32'd0);
    // load-use with avail_stage 2
    iq_head[0] = mk(8, 20, 21, EXE_LOAD, 2); iq_head[1] = mk(22, 8, 23, EXE_ALU, 1);
    step("load", 1);
    check("load type", 32'(fu_require[0].exe_type), 32'(EXE_LOAD));
    iq_head[0] = mk(22, 8, 23, EXE_ALU, 1); iq_size = 1;
    step("lu wait", 0);
    check("lu wait v0", 32'(fu_require[0].valid), 32'd0);
    step("lu go", 1);
    check("lu go num1", fu_require[0].num1, 32'hB000_0001);
    iq_head[0] = mk(24, 10, 11, EXE_ALU, 1); iq_size = 0;
    step("size0", 0);
    iq_head[0] = mk(26, 8, 27, EXE_ALU, 1); iq_head[1] = mk(28, 29, 30, EXE_ALU, 1); iq_size = 1;
    step("lu rf", 1);
    check("lu rf num1", fu_require[0].num1, 32'h1008);
    check("size1 v1", 32'(fu_require[1].valid), 32'd0);
    // branch in slot 1
    iq_head[0] = mk(31, 1, 2, EXE_ALU, 1); iq_head[1] = mk(0, 3, 4, EXE_BRANCH, 1); iq_size = 2;
    step("br1", 1);
    check("br1 v1", 32'(fu_require[1].valid), 32'd0);
    iq_head[0] = mk(0, 3, 4, EXE_BRANCH, 1); iq_size = 1;
    step("br0", 1);
    check("br0 type", 32'(fu_require[0].exe_type), 32'(EXE_BRANCH));
    check("br0 v0", 32'(fu_require[0].valid), 32'd1);
    // stall twice, then flush while stalled
    iq_head[0] = mk(5, 1, 2, EXE_ALU, 3);
    step("prod r5", 1);
    stall = 1'b1; iq_head[0] = mk(6, 5, 1, EXE_ALU, 1);
    step("stall1", 0);
    check("stall1 v0", 32'(fu_require[0].valid), 32'd1);
    check("stall1 dst", 32'(fu_require[0].dst_addr), 32'd5);
    iq_head[0] = mk(10, 11, 12, EXE_ALU, 1);
    step("stall2", 0);
    check("stall2 dst", 32'(fu_require[0].dst_addr), 32'd5);
    flush = 1'b1;
    step("flush", 0);
    check("flush v0", 32'(fu_require[0].valid), 32'd0);
    stall = 1'b0; flush = 1'b0; iq_head[0] = mk(6, 5, 1, EXE_ALU, 1);
    step("post flush", 1);
    check("post flush num1", fu_require[0].num1, 32'h1005);
    check("post flush num2", fu_require[0].num2, 32'h1001);
    // asynchronous reset with producers in flight
    iq_head[0] = mk(16, 1, 2, EXE_ALU, 3); iq_head[1] = mk(17, 3, 4, EXE_ALU, 3); iq_size = 2;
    step("prods", 2);
    check("prods v1", 32'(fu_require[1].valid), 32'd1);
    #2 rst = 1'b1;
    #1 check("async rst v0", 32'(fu_require[0].valid), 32'd0);
    check("async rst v1", 32'(fu_require[1].valid), 32'd0);
    #1 rst = 1'b0;
    iq_head[0] = mk(18, 16, 0, EXE_ALU, 1); iq_head[1] = mk(19, 17, 0, EXE_ALU, 1);
    step("after rst", 2);
    check("after rst s0 num1", fu_require[0].num1, 32'h1010);
    check("after rst s1 num1", fu_require[1].num1, 32'h1011);
    check("after rst s1 num2", fu_require[1].num2, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
